load_sched: RTL and testbench
=============================

// Module: load_sched
// PURPOSE
//  Arbitrates N load requesters onto the single vector tile loader and its memory port.
//  Accepts one request (address, bit length) at a time and drives the loader's start pulse.
//  Routes the loader's per-tile and done strobes back to the owning requester.
//  Checks each transfer's tile count. Sits between the instruction decoder's load paths and the loader.
// PARAMETERS
//  NUM_REQ     2    number of requesters (>=2)
//  ADDR_WIDTH  24   byte address width
//  LEN_WIDTH   10   transfer length width, in bits
//  TILE_WIDTH  256  loader tile size in bits; multiple of 8
// PORTS
//  clk              in   1                    clock, rising edge
//  rst_n            in   1                    async reset, active-low
//  req_valid        in   NUM_REQ              per-requester request valid
//  req_ready        out  NUM_REQ              one-hot grant/accept
//  req_addr         in   NUM_REQ*ADDR_WIDTH   per-requester start address, packed
//  req_len          in   NUM_REQ*LEN_WIDTH    per-requester length in bits, packed
//  resp_tile        out  NUM_REQ              1-cycle pulse per tile delivered to owner
//  resp_done        out  NUM_REQ              1-cycle pulse when owner's transfer completes
//  ld_valid_in      out  1                    loader start pulse
//  ld_addr          out  ADDR_WIDTH           loader start address, held while busy
//  ld_length        out  LEN_WIDTH            loader length, held while busy
//  ld_tile_out      in   1                    loader tile-complete strobe
//  ld_valid_out     in   1                    loader transfer-complete strobe
//  busy             out  1                    transfer in flight (state != IDLE)
//  owner            out  $clog2(NUM_REQ)      index of current/last granted requester
//  proto_err        out  1                    sticky protocol error flag
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; rr_ptr=0; proto_err=0; tile_cnt=0.
//  Reset mid-transfer aborts silently. The loader must share rst_n's domain.
//  The loader's reset is active-high; the top level inverts rst_n for it.
//  FSM IDLE->ISSUE->WAIT->DONE->IDLE:
//   IDLE: round-robin pick of the first req_valid at or after rr_ptr.
//    Assert req_ready[g] combinationally in the same cycle; accept = valid&&ready.
//    Latch addr/len, set owner=g, rr_ptr=(g+1)%NUM_REQ.
//    If len==0: go to DONE directly, with no loader start.
//    Otherwise go to ISSUE and compute exp_tiles=ceil(len/TILE_WIDTH).
//   ISSUE: ld_valid_in=1 for exactly one cycle, then WAIT.
//    Accept-to-start latency is 1 cycle.
//   WAIT: each ld_tile_out produces resp_tile[owner] in the next cycle and increments tile_cnt.
//    On ld_valid_out: if tile_cnt (including a coincident tile strobe) != exp_tiles, set proto_err.
//    Then go to DONE. Loader tile and done strobes may coincide; both are counted.
//   DONE: resp_done[owner]=1 for one cycle; clear tile_cnt; return to IDLE.
//    Minimum gap between grants: 1 cycle.
//  req_ready is 0 in every state except IDLE. At most one bit is set; never set in the reset cycle.
//  ld_tile_out or ld_valid_out outside WAIT: ignored, sets proto_err.
//  proto_err clears only on reset.
//  Requester deasserting valid before grant: no effect. Requests are not queued.
//  Width rules: exp_tiles uses LEN_WIDTH+1 bits, so no overflow at max len.
//   tile_cnt width is LEN_WIDTH bits, saturating.
// STRUCTURE
//  load_sched_pkg: state enum (IDLE, ISSUE, WAIT, DONE) and req-index typedef.
//  Sub-module rr_arbiter #(N): inputs req/ptr; outputs onehot grant and index; purely combinational.
//  ld_addr and ld_length are registered. resp_* outputs are registered.
// TESTING
//  1. Reset: hold rst_n=0 with req_valid=2'b11 -> all outputs 0; no grant until the first clk after release.
//  2. Single request r0 (addr 0x000100, len 512) -> ld_valid_in 1 cycle after accept.
//     Model loader gives 2 tiles plus done -> 2 resp_tile[0] pulses, 1 resp_done[0], proto_err=0.
//  3. Both requesters valid continuously, len 256 -> grants alternate r0,r1,r0,r1; owner tracks each grant.
//  4. r1 len=0 -> resp_done[1] 2 cycles after accept; ld_valid_in never pulses.
//  5. Model loader emits 1 tile and done for len 300 (expects 2) -> proto_err=1 and stays set.
//     Stray ld_tile_out in IDLE -> proto_err=1.
//  6. rst_n asserted in WAIT -> all outputs 0 asynchronously; a new request after release is granted to r0.

Source files
------------

// File: rtl/load_sched_pkg.sv
// load_sched shared types: FSM state and requester index.
// Imported by the scheduler top and its testbench.
package load_sched_pkg;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_IDX_W = $clog2(DEF_NUM_REQ);

  typedef logic [DEF_IDX_W-1:0] req_idx_t;
endpackage

// File: rtl/load_sched_if.sv
// Requester and loader bus of load_sched.
// master = requesters + loader, slave = scheduler.
interface load_sched_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 10
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ-1:0]            resp_tile;
  logic [NUM_REQ-1:0]            resp_done;
  logic                          ld_valid_in;
  logic [ADDR_WIDTH-1:0]         ld_addr;
  logic [LEN_WIDTH-1:0]          ld_length;
  logic                          ld_tile_out;
  logic                          ld_valid_out;

  modport master (
    output req_valid, req_addr, req_len,
    output ld_tile_out, ld_valid_out,
    input  req_ready, resp_tile, resp_done,
    input  ld_valid_in, ld_addr, ld_length
  );

  modport slave (
    input  req_valid, req_addr, req_len,
    input  ld_tile_out, ld_valid_out,
    output req_ready, resp_tile, resp_done,
    output ld_valid_in, ld_addr, ld_length
  );
endinterface

// File: rtl/load_sched_arb.sv
// Combinational round-robin picker: first request
// at or after the pointer, as one-hot and index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int i = 0; i < N; i++) begin
      w_j = {1'b0, i_ptr} + (IW+1)'(i);
      if (w_j >= (IW+1)'(N)) begin
        w_j = w_j - (IW+1)'(N);
      end
      if (!o_any && i_req[w_j[IW-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_j[IW-1:0];
        o_grant[w_j[IW-1:0]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/load_sched.sv
// Round-robin scheduler of N load requesters onto one
// tile loader, with tile-count protocol checking.
module load_sched
  import load_sched_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 10,
  parameter int TILE_WIDTH = 256,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          rst_n,
  load_sched_if.slave   bus,
  output logic          o_busy,
  output logic [IW-1:0] o_owner,
  output logic          o_proto_err
);
  localparam int LW1 = LEN_WIDTH + 1;

  state_t                r_state;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_tile_cnt;
  logic [LW1-1:0]        r_exp;
  logic                  r_ld_valid;
  logic                  r_err;
  logic [NUM_REQ-1:0]    r_tile;
  logic [NUM_REQ-1:0]    r_done;

  logic [NUM_REQ-1:0]    w_grant;
  logic [IW-1:0]         w_idx;
  logic                  w_any;
  logic                  w_idle;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [LEN_WIDTH-1:0]  w_sel_len;
  logic [31:0]           w_sum;
  logic [LW1-1:0]        w_exp;
  logic [LW1-1:0]        w_cnt_tot;
  logic                  w_stray;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IW'(i)) begin
        w_sel_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_len  = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // rst_n gate keeps ready low while reset is held
  assign w_idle    = (r_state == IDLE) && rst_n;
  assign w_sum     = 32'(w_sel_len) + 32'(TILE_WIDTH - 1);
  assign w_exp     = LW1'(w_sum / 32'(TILE_WIDTH));
  assign w_cnt_tot = {1'b0, r_tile_cnt} + LW1'(bus.ld_tile_out);
  assign w_stray   = (r_state != WAIT) &&
                     (bus.ld_tile_out || bus.ld_valid_out);

  assign bus.req_ready   = w_idle ? w_grant : '0;
  assign bus.resp_tile   = r_tile;
  assign bus.resp_done   = r_done;
  assign bus.ld_valid_in = r_ld_valid;
  assign bus.ld_addr     = r_addr;
  assign bus.ld_length   = r_len;
  assign o_busy          = (r_state != IDLE);
  assign o_owner         = r_owner;
  assign o_proto_err     = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_tile_cnt <= '0;
      r_exp      <= '0;
      r_ld_valid <= 1'b0;
      r_err      <= 1'b0;
      r_tile     <= '0;
      r_done     <= '0;
    end else begin
      r_tile     <= '0;
      r_done     <= '0;
      r_ld_valid <= 1'b0;
      if (w_stray) begin
        r_err <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_addr  <= w_sel_addr;
            r_len   <= w_sel_len;
            r_exp   <= w_exp;
            r_owner <= w_idx;
            r_ptr   <= (int'(w_idx) == NUM_REQ - 1) ?
                       '0 : w_idx + 1'b1;
            if (w_sel_len == '0) begin
              r_state <= DONE;
            end else begin
              r_state    <= ISSUE;
              r_ld_valid <= 1'b1;
            end
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (bus.ld_tile_out) begin
            r_tile[r_owner] <= 1'b1;
            if (~&r_tile_cnt) begin
              r_tile_cnt <= r_tile_cnt + 1'b1;
            end
          end
          if (bus.ld_valid_out) begin
            if (w_cnt_tot != r_exp) begin
              r_err <= 1'b1;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done[r_owner] <= 1'b1;
          r_tile_cnt      <= '0;
          r_state         <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_sched.sv
// Self-checking bench for load_sched: vector table,
// reset/stray corner cases and a random transaction model.
module tb_load_sched;
  import load_sched_pkg::*;

  localparam int N  = 2;
  localparam int AW = 24;
  localparam int LW = 10;
  localparam int TW = 256;

  typedef struct {
    logic [N-1:0] mask;
    int           len;
    int           ntiles;
    bit           coin;
    int           eg;
    bit           eerr;
  } vec_t;

  logic     clk;
  logic     rst_n;
  logic     busy;
  req_idx_t owner;
  logic     perr;

  int n_chk;
  int n_fail;
  int tiles_seen [N];
  int done_seen [N];
  int ldv_seen;
  vec_t tbl [9];

  load_sched_if #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) bif ();

  load_sched #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .TILE_WIDTH (TW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bif),
    .o_busy      (busy),
    .o_owner     (owner),
    .o_proto_err (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      tiles_seen[i] += int'(bif.resp_tile[i]);
      done_seen[i]  += int'(bif.resp_done[i]);
    end
    ldv_seen += int'(bif.ld_valid_in);
  endtask

  function automatic logic [AW-1:0] addr_of(
      input logic [AW-1:0] base, input int i);
    return base + AW'(i * 65536);
  endfunction

  function automatic int ceil_tiles(input int len);
    int t;
    t = len / TW;
    if (t * TW < len) t++;
    return t;
  endfunction

  task automatic set_req(input logic [N-1:0] mask,
                         input int len,
                         input logic [AW-1:0] base);
    bif.req_valid = mask;
    for (int i = 0; i < N; i++) begin
      bif.req_addr[i*AW +: AW] = addr_of(base, i);
      bif.req_len[i*LW +: LW]  = LW'(len);
    end
  endtask

  task automatic chk_idle_zero(input string name);
    chk({name, "_addr"}, 32'(bif.ld_addr), 32'd0);
    chk({name, "_misc"},
        32'({busy, owner, perr, bif.ld_valid_in,
             bif.req_ready, bif.resp_tile,
             bif.resp_done, bif.ld_length}), 32'd0);
  endtask

  task automatic xfer(input logic [N-1:0] mask,
                      input logic [AW-1:0] base,
                      input int len, input int ntiles,
                      input bit coin, input int eg,
                      input bit eerr);
    logic [N-1:0] eg_oh;
    int own_t, tot_t, own_d, tot_d;
    eg_oh = N'(1) << eg;
    for (int i = 0; i < N; i++) begin
      tiles_seen[i] = 0;
      done_seen[i]  = 0;
    end
    ldv_seen = 0;
    set_req(mask, len, base);
    #1;
    chk("req_ready", 32'(bif.req_ready), 32'(eg_oh));
    step();
    bif.req_valid = '0;
    chk("owner", 32'(owner), 32'(eg));
    chk("busy_run", 32'(busy), 32'd1);
    if (len != 0) begin
      chk("ld_valid_in", 32'(bif.ld_valid_in), 32'd1);
      chk("ld_addr", 32'(bif.ld_addr),
          32'(addr_of(base, eg)));
      chk("ld_length", 32'(bif.ld_length), 32'(len));
      step();
      chk("ld_valid_drop", 32'(bif.ld_valid_in), 32'd0);
      for (int k = 0; k < ntiles; k++) begin
        repeat ($urandom_range(0, 2)) step();
        bif.ld_tile_out = 1'b1;
        if (coin && k == ntiles - 1) bif.ld_valid_out = 1'b1;
        step();
        bif.ld_tile_out  = 1'b0;
        bif.ld_valid_out = 1'b0;
      end
      if (!(coin && ntiles > 0)) begin
        repeat ($urandom_range(0, 2)) step();
        bif.ld_valid_out = 1'b1;
        step();
        bif.ld_valid_out = 1'b0;
      end
      step();
    end else begin
      chk("len0_no_start", 32'(bif.ld_valid_in), 32'd0);
      step();
      chk("len0_done", 32'(bif.resp_done), 32'(eg_oh));
    end
    step();
    own_t = 0; tot_t = 0; own_d = 0; tot_d = 0;
    for (int i = 0; i < N; i++) begin
      tot_t += tiles_seen[i];
      tot_d += done_seen[i];
      if (i == eg) begin
        own_t = tiles_seen[i];
        own_d = done_seen[i];
      end
    end
    chk("tiles_owner", 32'(own_t), 32'(ntiles));
    chk("tiles_total", 32'(tot_t), 32'(ntiles));
    chk("done_owner", 32'(own_d), 32'd1);
    chk("done_total", 32'(tot_d), 32'd1);
    chk("start_count", 32'(ldv_seen), (len != 0) ? 32'd1 : 32'd0);
    chk("proto_err", 32'(perr), 32'(eerr));
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] mask;
    logic [AW-1:0] base;
    int len, nt, ct, g, mp;
    bit coin, merr, found;

    n_chk = 0;
    n_fail = 0;
    ldv_seen = 0;
    rst_n = 1'b1;
    bif.ld_tile_out  = 1'b0;
    bif.ld_valid_out = 1'b0;
    set_req(2'b11, 256, 24'h000100);

    tbl[0] = '{2'b01,  512, 2, 1'b0, 0, 1'b0};
    tbl[1] = '{2'b11,  256, 1, 1'b0, 1, 1'b0};
    tbl[2] = '{2'b11,  256, 1, 1'b1, 0, 1'b0};
    tbl[3] = '{2'b11,  256, 1, 1'b0, 1, 1'b0};
    tbl[4] = '{2'b10,    0, 0, 1'b0, 1, 1'b0};
    tbl[5] = '{2'b11,    1, 1, 1'b1, 0, 1'b0};
    tbl[6] = '{2'b01, 1023, 4, 1'b1, 0, 1'b0};
    tbl[7] = '{2'b10,  300, 1, 1'b0, 1, 1'b1};
    tbl[8] = '{2'b01,  256, 1, 1'b0, 0, 1'b1};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset_hold");
    bif.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset_ready", 32'(bif.req_ready), 32'd0);

    for (int v = 0; v < 9; v++) begin
      xfer(tbl[v].mask, 24'h000100, tbl[v].len,
           tbl[v].ntiles, tbl[v].coin, tbl[v].eg,
           tbl[v].eerr);
    end

    set_req(2'b11, 256, 24'h000100);
    #1;
    chk("rst_seq_ready", 32'(bif.req_ready), 32'd2);
    step();
    bif.req_valid = '0;
    step();
    step();
    chk("rst_seq_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    xfer(2'b11, 24'h000100, 0, 0, 1'b0, 0, 1'b0);

    bif.ld_tile_out = 1'b1;
    step();
    bif.ld_tile_out = 1'b0;
    chk("stray_tile_err", 32'(perr), 32'd1);
    step();
    chk("stray_sticky", 32'(perr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("err_reset_clear", 32'(perr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mp = 0;
    merr = 1'b0;
    for (int it = 0; it < 40; it++) begin
      mask = N'($urandom_range(1, 3));
      len  = ($urandom_range(0, 3) == 0) ?
             0 : int'($urandom_range(1, 1023));
      base = AW'($urandom);
      g = 0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && mask[(mp + i) % N]) begin
          found = 1'b1;
          g = (mp + i) % N;
        end
      end
      ct = (len == 0) ? 0 : ceil_tiles(len);
      nt = ct;
      if (it >= 30 && len != 0 && $urandom_range(0, 2) == 0) begin
        nt = $urandom_range(0, 1) ? ct + 1 : ct - 1;
      end
      if (nt != ct) merr = 1'b1;
      coin = (nt > 0) && ($urandom_range(0, 1) == 1);
      xfer(mask, base, len, nt, coin, g, merr);
      mp = (g + 1) % N;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
